l2_hdr_capture_ctrl: RTL

Sequencing controller for the L2 header capture path. It sits between the ingress AXI-Stream slave and the parser datapath, and drives the header shift register's `frame_start`, `beat_accept` and `in_l2_header` controls. It also detects frame boundaries, short (runt) and oversize frames, and hands each completed header to the downstream classifier with a req/ack handshake. A new frame is not admitted while the previous header is still unacknowledged.

---
 rtl/l2_hdr_capture_ctrl_if.sv | 38 +++
 rtl/l2_hdr_capture_ctrl.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/l2_hdr_capture_ctrl_if.sv
// l2_hdr_capture_ctrl_if: handshake bundle around the L2 header capture
// controller. Carries the ingress and downstream stream handshakes (the data
// bus itself is routed elsewhere) and the header req/ack pair to the
// classifier.
//   master : the capture controller (owns tready, downstream valid/last, hdr_req)
//   slave  : the surrounding stream source/sink and classifier
interface l2_hdr_capture_ctrl_if;
    logic s_axis_tvalid;
    logic s_axis_tlast;
    logic s_axis_tready;
    logic m_axis_tvalid;
    logic m_axis_tlast;
    logic m_axis_tready;
    logic hdr_req;
    logic hdr_ack;

    modport master (
        input  s_axis_tvalid,
        input  s_axis_tlast,
        output s_axis_tready,
        output m_axis_tvalid,
        output m_axis_tlast,
        input  m_axis_tready,
        output hdr_req,
        input  hdr_ack
    );

    modport slave (
        output s_axis_tvalid,
        output s_axis_tlast,
        input  s_axis_tready,
        input  m_axis_tvalid,
        input  m_axis_tlast,
        output m_axis_tready,
        input  hdr_req,
        output hdr_ack
    );
endinterface

// File: rtl/l2_hdr_capture_ctrl.sv
// l2_hdr_capture_ctrl: sequencing controller for the L2 header capture path.
// Admits frames from the ingress stream, drives the header shift register
// controls (frame_start / beat_accept / in_l2_header), flags runt and
// oversize frames, and hands each completed header to the classifier over
// hdr_req/hdr_ack. A new frame is held off while a header is unacknowledged.
// Optional feature: define L2CTRL_STATS_EN to compile in the frame and runt
// statistics counters; without it frame_count/runt_count are tied to zero.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | ingress stalled; waiting for tvalid with no header pending
// START   | one-cycle frame_start clear of the shift register, no accept
// HEADER  | accepting the first HDR_BEATS beats, in_l2_header high
// PAYLOAD | passing the remainder of the frame through until tlast
module l2_hdr_capture_ctrl #(
    parameter int DATA_WIDTH          = 64,
    parameter int L2_HEADER_MAX_BYTES = 18,
    parameter int MAX_FRAME_BEATS     = 1024
) (
    input  logic                         clk,
    input  logic                         rst,
    l2_hdr_capture_ctrl_if.master        bus,
    output logic                         frame_start,
    output logic                         beat_accept,
    output logic                         in_l2_header,
    input  logic                         header_valid,
    output logic                         err_runt,
    output logic                         err_oversize,
    output logic [31:0]                  frame_count,
    output logic [15:0]                  runt_count
);

    localparam int BPB       = DATA_WIDTH / 8;
    localparam int HDR_BEATS = (L2_HEADER_MAX_BYTES + BPB - 1) / BPB;
    localparam int CNT_W     = $clog2(MAX_FRAME_BEATS + 2);

    localparam logic [CNT_W-1:0] HDR_LAST_IDX = CNT_W'(HDR_BEATS - 1);
    localparam logic [CNT_W-1:0] CNT_MAX      = CNT_W'(MAX_FRAME_BEATS);
    localparam logic [CNT_W-1:0] CNT_SAT      = CNT_W'(MAX_FRAME_BEATS + 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_START   = 2'd1,
        ST_HEADER  = 2'd2,
        ST_PAYLOAD = 2'd3
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] beat_cnt;
    logic             hdr_req_q;
    logic             header_valid_q;
    logic             passthru;
    logic             last_accept;
    logic             runt_hit;

    // Stream passthrough is only open while a frame is being carried; IDLE
    // and START present a stalled, idle interface in both directions.
    assign passthru          = (state == ST_HEADER) || (state == ST_PAYLOAD);
    assign bus.s_axis_tready = passthru & bus.m_axis_tready;
    assign bus.m_axis_tvalid = passthru & bus.s_axis_tvalid;
    assign bus.m_axis_tlast  = passthru & bus.s_axis_tlast;
    assign beat_accept       = bus.s_axis_tvalid & bus.s_axis_tready;
    assign last_accept       = beat_accept & bus.s_axis_tlast;
    assign runt_hit          = (state == ST_HEADER) && last_accept && (beat_cnt < HDR_LAST_IDX);
    assign bus.hdr_req       = hdr_req_q;

    // Frame sequencer: state, beat counter and the registered control/error pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= ST_IDLE;
            beat_cnt     <= '0;
            frame_start  <= 1'b0;
            in_l2_header <= 1'b0;
            err_runt     <= 1'b0;
            err_oversize <= 1'b0;
        end else begin
            frame_start  <= 1'b0;
            err_runt     <= 1'b0;
            err_oversize <= 1'b0;

            // Saturating count keeps the oversize pulse to one per frame.
            if (beat_accept && (beat_cnt != CNT_SAT)) begin
                beat_cnt <= beat_cnt + CNT_W'(1);
            end
            if (beat_accept && (beat_cnt == CNT_MAX)) begin
                err_oversize <= 1'b1;
            end

            case (state)
                ST_IDLE: begin
                    if (bus.s_axis_tvalid && !hdr_req_q) begin
                        state       <= ST_START;
                        frame_start <= 1'b1;
                    end
                end
                ST_START: begin
                    state        <= ST_HEADER;
                    beat_cnt     <= '0;
                    in_l2_header <= 1'b1;
                end
                ST_HEADER: begin
                    if (beat_accept) begin
                        if (beat_cnt == HDR_LAST_IDX) begin
                            in_l2_header <= 1'b0;
                            state        <= bus.s_axis_tlast ? ST_IDLE : ST_PAYLOAD;
                        end else if (bus.s_axis_tlast) begin
                            in_l2_header <= 1'b0;
                            err_runt     <= 1'b1;
                            state        <= ST_IDLE;
                        end
                    end
                end
                ST_PAYLOAD: begin
                    if (last_accept) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state        <= ST_IDLE;
                    in_l2_header <= 1'b0;
                end
            endcase
        end
    end

    // Header handoff: raise hdr_req on a rising header_valid, drop it once acked.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            header_valid_q <= 1'b0;
            hdr_req_q      <= 1'b0;
        end else begin
            header_valid_q <= header_valid;
            if (header_valid && !header_valid_q) begin
                hdr_req_q <= 1'b1;
            end else if (hdr_req_q && bus.hdr_ack) begin
                hdr_req_q <= 1'b0;
            end
        end
    end

`ifdef L2CTRL_STATS_EN
    logic [31:0] frame_cnt_q;
    logic [15:0] runt_cnt_q;

    // Statistics: completed frames wrap, runts saturate.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_cnt_q <= '0;
            runt_cnt_q  <= '0;
        end else begin
            if (last_accept) begin
                frame_cnt_q <= frame_cnt_q + 32'd1;
            end
            if (runt_hit && (runt_cnt_q != 16'hFFFF)) begin
                runt_cnt_q <= runt_cnt_q + 16'd1;
            end
        end
    end

    assign frame_count = frame_cnt_q;
    assign runt_count  = runt_cnt_q;
`else
    assign frame_count = '0;
    assign runt_count  = '0;
`endif

endmodule
